// File: rtl/traffic_phase_scheduler.sv
// traffic_phase_scheduler: tick-timed green/yellow/all-red/walk sequencer for a two-road crossing.
module traffic_phase_scheduler #(
  parameter int GREEN_MIN = 8,
  parameter int GREEN_MAX = 32,
  parameter int YELLOW_T  = 3,
  parameter int ALLRED_T  = 1,
  parameter int WALK_T    = 6,
  parameter int CNT_W     = 6
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_tick,
  input  logic       i_car_a,
  input  logic       i_car_b,
  input  logic       i_ped_req,
  output logic [1:0] o_LA,
  output logic [1:0] o_LB,
  output logic       o_walk,
  output logic       o_ped_ack,
  output logic [2:0] o_phase
);
  typedef enum logic [2:0] {
    A_GRN = 3'd0,
    A_YEL = 3'd1,
    AR_AB = 3'd2,
    B_GRN = 3'd3,
    B_YEL = 3'd4,
    AR_BA = 3'd5,
    WALK  = 3'd6
  } state_t;
  localparam logic [CNT_W:0]   G_MIN  = (CNT_W+1)'(GREEN_MIN);
  localparam logic [CNT_W:0]   G_MAX  = (CNT_W+1)'(GREEN_MAX);
  localparam logic [CNT_W-1:0] C_MAX  = CNT_W'(GREEN_MAX);
  localparam logic [CNT_W-1:0] Y_END  = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] R_END  = CNT_W'(ALLRED_T - 1);
  localparam logic [CNT_W-1:0] W_END  = CNT_W'(WALK_T - 1);
  state_t          state, nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W:0]   cnt1;
  logic            ped_pend, next_b;
  logic            done_y, done_r, done_w, go_a, go_b, enter_walk;
  always_comb begin
    cnt1   = {1'b0, cnt} + (CNT_W+1)'(1);
    done_y = i_tick && cnt == Y_END;
    done_r = i_tick && cnt == R_END;
    done_w = i_tick && cnt == W_END;
    // a green yields only after its minimum, to real cross demand, and once extension stops or hits the cap
    go_a   = i_tick && cnt1 >= G_MIN && (i_car_b || ped_pend) && (!i_car_a || cnt1 >= G_MAX);
    go_b   = i_tick && cnt1 >= G_MIN && (i_car_a || ped_pend) && (!i_car_b || cnt1 >= G_MAX);
    case (state)
      A_GRN:   nxt = go_a ? A_YEL : A_GRN;
      A_YEL:   nxt = done_y ? AR_AB : A_YEL;
      AR_AB:   nxt = !done_r ? AR_AB : ped_pend ? WALK : B_GRN;
      B_GRN:   nxt = go_b ? B_YEL : B_GRN;
      B_YEL:   nxt = done_y ? AR_BA : B_YEL;
      AR_BA:   nxt = !done_r ? AR_BA : ped_pend ? WALK : A_GRN;
      WALK:    nxt = !done_w ? WALK : next_b ? B_GRN : A_GRN;
      default: nxt = A_GRN;
    endcase
    enter_walk = nxt == WALK && state != WALK;
  end
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      state     <= A_GRN;
      cnt       <= '0;
      ped_pend  <= 1'b0;
      next_b    <= 1'b1;
      o_ped_ack <= 1'b0;
    end else begin
      state     <= nxt;
      cnt       <= nxt != state ? '0 : (i_tick && cnt != C_MAX) ? cnt1[CNT_W-1:0] : cnt;
      ped_pend  <= enter_walk ? 1'b0 : ped_pend | i_ped_req;
      next_b    <= enter_walk ? state == AR_AB : next_b;
      o_ped_ack <= enter_walk;
    end
  always_comb begin
    o_LA    = state == A_GRN ? 2'd0 : state == A_YEL ? 2'd1 : 2'd2;
    o_LB    = state == B_GRN ? 2'd0 : state == B_YEL ? 2'd1 : 2'd2;
    o_walk  = state == WALK;
    o_phase = state;
  end
endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// tb_traffic_phase_scheduler: per-cycle expected lamp/phase records queued by stimulus, checked by a monitor.
module tb_traffic_phase_scheduler;
  logic       i_clk = 1'b0, i_rst = 1'b0, i_tick = 1'b0;
  logic       i_car_a = 1'b0, i_car_b = 1'b0, i_ped_req = 1'b0;
  logic [1:0] o_LA, o_LB;
  logic       o_walk, o_ped_ack;
  logic [2:0] o_phase;
  logic [8:0] act;
  logic [8:0] q[$];
  logic [8:0] e;
  int         errors = 0, checks = 0, idx = 0;
  string      tname = "init";
  traffic_phase_scheduler #(
    .GREEN_MIN(4), .GREEN_MAX(8), .YELLOW_T(2), .ALLRED_T(1), .WALK_T(3), .CNT_W(6)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_tick(i_tick), .i_car_a(i_car_a), .i_car_b(i_car_b),
    .i_ped_req(i_ped_req), .o_LA(o_LA), .o_LB(o_LB), .o_walk(o_walk), .o_ped_ack(o_ped_ack),
    .o_phase(o_phase)
  );
  always #5 i_clk = ~i_clk;
  assign act = {o_phase, o_LA, o_LB, o_walk, o_ped_ack};
  function automatic void check(string name, logic [8:0] got, logic [8:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got phase=%0d LA=%0d LB=%0d walk=%0b ack=%0b, want phase=%0d LA=%0d LB=%0d walk=%0b ack=%0b",
               name, got[8:6], got[5:4], got[3:2], got[1], got[0], exp[8:6], exp[5:4], exp[3:2], exp[1], exp[0]);
    end
  endfunction
  function automatic logic [8:0] rec(int ph, bit ack);
    logic [1:0] la, lb;
    la = ph == 0 ? 2'd0 : ph == 1 ? 2'd1 : 2'd2;
    lb = ph == 3 ? 2'd0 : ph == 4 ? 2'd1 : 2'd2;
    return {3'(ph), la, lb, ph == 6, ack};
  endfunction
  always @(negedge i_clk)
    if (!i_rst && q.size() > 0) begin
      e = q.pop_front();
      check($sformatf("%s cyc%0d", tname, idx), act, e);
      idx++;
    end
  task automatic push(int ph, int n, bit ack_first);
    for (int i = 0; i < n; i++) q.push_back(rec(ph, ack_first && i == 0));
  endtask
  task automatic start(string name, logic ca, logic cb);
    @(posedge i_clk);
    #1 i_rst = 1'b1;
    tname = name;
    idx = 0;
    i_car_a = ca;
    i_car_b = cb;
    i_ped_req = 1'b0;
    i_tick = 1'b0;
  endtask
  task automatic release_rst();
    @(posedge i_clk);
    #1 i_rst = 1'b0;
  endtask
  task automatic run(int n, int tmod, int ped_at);
    for (int k = 0; k < n; k++) begin
      i_tick = (k % tmod) == tmod - 1;
      i_ped_req = k == ped_at;
      @(posedge i_clk);
      #1;
    end
    i_ped_req = 1'b0;
  endtask
  task automatic drain();
    int b = 0;
    while (q.size() > 0 && b < 200) begin
      @(negedge i_clk);
      b++;
    end
    #1;
    if (q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL %s drain: %0d expected records left, want 0", tname, q.size());
      q.delete();
    end
  endtask
  initial begin
    #3 i_rst = 1'b1;
    #1 check("reset_no_edge", act, rec(0, 0));
    tname = "rest";
    push(0, 100, 0);
    release_rst();
    run(100, 1, -1);
    drain();
    start("cross", 0, 1);
    push(0, 4, 0); push(1, 2, 0); push(2, 1, 0); push(3, 6, 0);
    release_rst();
    run(13, 1, -1);
    drain();
    start("extend", 1, 1);
    push(0, 8, 0); push(1, 2, 0); push(2, 1, 0); push(3, 8, 0);
    push(4, 2, 0); push(5, 1, 0); push(0, 8, 0);
    release_rst();
    run(30, 1, -1);
    drain();
    start("ped", 0, 0);
    push(0, 4, 0); push(1, 2, 0); push(2, 1, 0); push(6, 3, 1); push(3, 10, 0);
    release_rst();
    run(20, 1, 1);
    drain();
    start("tick_gate", 0, 1);
    push(0, 16, 0); push(1, 8, 0); push(2, 4, 0); push(6, 12, 1); push(3, 8, 0);
    release_rst();
    run(48, 4, 5);
    drain();
    start("mid_reset", 0, 1);
    push(0, 4, 0); push(1, 1, 0);
    release_rst();
    run(5, 1, -1);
    drain();
    #1 i_rst = 1'b1;
    #1 check("mid_reset async", act, rec(0, 0));
    tname = "fresh_green";
    idx = 0;
    push(0, 4, 0); push(1, 2, 0);
    release_rst();
    run(6, 1, -1);
    drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/traffic_phase_scheduler.md
# traffic_phase_scheduler

Timed phase scheduler for a two-road intersection with a pedestrian crossing. It sequences green, yellow, all-red and walk phases using tick-based duration counters. Green is held for a minimum time, extended by same-road sensor activity up to a maximum, and yielded only when the opposing road or a pedestrian has demand. It sits above the lamp drivers and produces the per-road lamp codes and the walk signal directly.

## Interface
Parameters:
- GREEN_MIN, 8: minimum green duration in ticks (>=1)
- GREEN_MAX, 32: maximum extended green in ticks (>=GREEN_MIN)
- YELLOW_T, 3: yellow duration in ticks (>=1)
- ALLRED_T, 1: all-red clearance in ticks (>=1)
- WALK_T, 6: pedestrian walk duration in ticks (>=1)
- CNT_W, 6: phase counter width; must hold GREEN_MAX

Ports:
- i_clk  in  1  clock, rising edge
- i_rst  in  1  reset, asynchronous, active-high
- i_tick  in  1  timebase enable; phase counters advance only on cycles with i_tick=1
- i_car_a  in  1  vehicle present on road A (level)
- i_car_b  in  1  vehicle present on road B (level)
- i_ped_req  in  1  pedestrian button (pulse or level; latched internally)
- o_LA  out  2  road A lamp: 0=GREEN, 1=YELLOW, 2=RED
- o_LB  out  2  road B lamp, same encoding
- o_walk  out  1  pedestrian walk lamp
- o_ped_ack  out  1  one-cycle pulse on the first cycle of WALK
- o_phase  out  3  current state encoding (debug)

## Operation
- Seven states, encoded as: A_GRN=0, A_YEL=1, AR_AB=2, B_GRN=3, B_YEL=4, AR_BA=5, WALK=6. Codes 7 are illegal and recover to A_GRN next edge.
- Lamp decode (Moore, from the registered state):
  - A_GRN: LA=GREEN, LB=RED
  - A_YEL: LA=YELLOW, LB=RED
  - B_GRN: LA=RED, LB=GREEN
  - B_YEL: LA=RED, LB=YELLOW
  - AR_*, WALK: both RED
  - o_walk=1 only in WALK.
- `cnt`: ticks elapsed in the current state. Cleared on every state change. Incremented on i_tick; saturates at GREEN_MAX.
- `ped_pend`: set by i_ped_req=1. Cleared on the edge that enters WALK. A request arriving on that same edge is absorbed (cleared). A request during WALK sets it again.
- `next_b`: records which green follows WALK. Set to 1 when leaving AR_AB into WALK; set to 0 when leaving AR_BA into WALK.
- Let done(T) = i_tick && (cnt == T-1). Every state therefore lasts exactly T ticks.
- A_GRN -> A_YEL when all of the following hold:
  - i_tick=1
  - cnt+1 >= GREEN_MIN
  - demand_b = (i_car_b | ped_pend)
  - (!i_car_a || cnt+1 >= GREEN_MAX)
- If there is no demand, A_GRN rests indefinitely.
- B_GRN -> B_YEL: symmetric, with demand_a = (i_car_a | ped_pend) and extension by i_car_b.
- A_YEL -> AR_AB on done(YELLOW_T).
- B_YEL -> AR_BA on done(YELLOW_T).
- AR_AB -> WALK if ped_pend, else B_GRN, on done(ALLRED_T).
- AR_BA -> WALK if ped_pend, else A_GRN, on done(ALLRED_T).
- WALK -> B_GRN if next_b, else A_GRN, on done(WALK_T).
- Sensor inputs are sampled only on tick cycles. They are assumed synchronous to i_clk; synchronisers live upstream.

## Timing
- Reset (asynchronous, takes effect immediately without a clock edge):
  - state=A_GRN, cnt=0, ped_pend=0, next_b=1
  - o_LA=0, o_LB=2, o_walk=0, o_ped_ack=0, o_phase=0
- State and all outputs update on the same rising edge that satisfies a transition; there is no extra output latency.
- o_ped_ack is high for exactly the first i_clk cycle of WALK, independent of i_tick.
- i_tick=0 freezes cnt and state. i_ped_req is still latched on those cycles.
- If demand and GREEN_MAX coincide with i_car_a=1, the transition is taken (the maximum wins).
- Asserting i_rst mid-phase aborts immediately to A_GRN. Any pending pedestrian request is lost.

## Test plan
Unless stated otherwise: GREEN_MIN=4, GREEN_MAX=8, YELLOW_T=2, ALLRED_T=1, WALK_T=3, i_tick=1 every cycle.
- Reset/rest: pulse i_rst, all sensors 0 -> LA=0, LB=2, o_phase=0 held for 100 cycles. Check outputs during reset without clock edges.
- Cross demand: i_car_b=1, i_car_a=0 from reset -> A_GRN 4 cycles, A_YEL 2, AR_AB 1, then B_GRN (LA=2, LB=0) at cycle 7.
- Extension: i_car_a=1 and i_car_b=1 -> A_GRN lasts 8 cycles, then B_GRN lasts 8 cycles, repeating with 3-cycle clearance each side.
- Pedestrian: single i_ped_req pulse at cycle 1, no cars ->
  - A_GRN 4, A_YEL 2, AR_AB 1, then WALK 3 with o_walk=1 and o_ped_ack high only at cycle 7
  - then B_GRN, resting there.
- Tick gating: i_tick high 1 cycle in 4 with i_car_b=1 -> A_GRN lasts 16 clocks and A_YEL lasts 8 clocks. A ped pulse on a tick-low cycle is still served.
- Reset mid-operation: assert i_rst during A_YEL -> LA=0, LB=2 before the next edge. After release, a fresh 4-tick minimum green is served.
